oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl.sv | 93 +++++++++
 tb/tb_oam_dma_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - OAM DMA sequencer: halts the CPU and copies one 256-byte page to a fixed port.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  bus_rdata,
    output logic        stall,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_rd,
    output logic        dma_we,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q;
    logic        trigger;

    assign trigger = cpu_we && (cpu_addr == TRIG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            cnt_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        stall     = 1'b1;
        dma_addr  = 16'h0000;
        dma_wdata = 8'h00;
        dma_rd    = 1'b0;
        dma_we    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = 1'b0;
                if (trigger) begin
                    page_d  = cpu_wdata;
                    cnt_d   = 8'h00;
                    state_d = HALT;
                end
            end
            // An odd-parity halt inserts ALIGN so every READ starts on an odd cycle.
            HALT:  state_d = parity_q ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
                dma_addr = {page_q, cnt_q};
                dma_rd   = 1'b1;
                data_d   = bus_rdata;
                state_d  = WRITE;
            end
            WRITE: begin
                dma_addr  = DEST_ADDR;
                dma_we    = 1'b1;
                dma_wdata = data_q;
                cnt_d     = cnt_q + 8'd1;
                state_d   = (cnt_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
        busy = stall;
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - directed self-checking bench for oam_dma_ctrl.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  bus_rdata;
    logic        stall;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rd;
    logic        dma_we;
    logic        busy;

    int tests = 0;
    int fails = 0;
    bit mem_lb = 1'b0;
    bit tb_par = 1'b0;

    oam_dma_ctrl dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .bus_rdata(bus_rdata), .stall(stall), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rd(dma_rd), .dma_we(dma_we), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected cycle parity: cleared by reset, toggles on every other edge.
    always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

    function automatic logic [7:0] mem(input logic [15:0] a, input bit lb);
        return lb ? a[7:0] : (a[7:0] ^ a[15:8] ^ 8'hA5);
    endfunction

    assign bus_rdata = mem(dma_addr, mem_lb);

    task automatic clear_cpu();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic check_quiet(input string name);
        tests++;
        if ({stall, busy, dma_rd, dma_we} !== 4'b0000 || dma_addr !== 16'h0000 || dma_wdata !== 8'h00) begin
            fails++;
            $display("FAIL %s: stall/busy/rd/we=%b addr=%h wdata=%h, required 0000/0000/00",
                     name, {stall, busy, dma_rd, dma_we}, dma_addr, dma_wdata);
        end
    endtask

    // want: required parity of the HALT cycle, or -1 for whatever comes next.
    task automatic start(input logic [7:0] pg, input int want);
        if (want >= 0 && tb_par == want[0]) @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = pg;
        @(negedge clk);
        clear_cpu();
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL start_halt: stall=%b, required 1", stall);
        end
    endtask

    task automatic monitor(input logic [7:0] pg, input int retrig_at, input bit b2b, input logic [7:0] pg2);
        int len = 0, nrd = 0, nwr = 0, pre = 0;
        logic [7:0] exp_d = 8'h00;
        logic [7:0] last_wd = 8'h00;
        bit hp;
        hp = tb_par;
        while (stall === 1'b1 && len < 600) begin
            if (len == retrig_at + 1) clear_cpu();
            tests++;
            if (busy !== stall || (dma_rd & dma_we) !== 1'b0) begin
                fails++;
                $display("FAIL busy_rdwe cyc %0d: busy=%b rd=%b we=%b, required busy=1 and not both", len, busy, dma_rd, dma_we);
            end
            if (dma_rd === 1'b1) begin
                tests++;
                if (dma_addr !== {pg, nrd[7:0]} || nwr != nrd) begin
                    fails++;
                    $display("FAIL read_addr %0d: addr=%h writes=%0d, required %h writes=%0d", nrd, dma_addr, nwr, {pg, nrd[7:0]}, nrd);
                end
                exp_d = mem({pg, nrd[7:0]}, mem_lb);
                nrd++;
            end else if (dma_we === 1'b1) begin
                tests++;
                if (dma_addr !== 16'h2004 || dma_wdata !== exp_d) begin
                    fails++;
                    $display("FAIL write %0d: addr=%h wdata=%h, required 2004 %h", nwr, dma_addr, dma_wdata, exp_d);
                end
                last_wd = dma_wdata;
                nwr++;
                if (b2b && nwr == 256) begin
                    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = pg2;
                end
            end else begin
                tests++;
                if (dma_addr !== 16'h0000 || dma_wdata !== 8'h00 || nrd != 0) begin
                    fails++;
                    $display("FAIL halt_cycle %0d: addr=%h wdata=%h reads=%0d, required 0000 00 0", len, dma_addr, dma_wdata, nrd);
                end
                pre++;
            end
            if (len == retrig_at) begin
                cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h05;
            end
            len++;
            @(negedge clk);
        end
        tests++;
        if (len != 513 + int'(hp) || pre != 1 + int'(hp)) begin
            fails++;
            $display("FAIL length: stall=%0d pre=%0d, required %0d pre=%0d", len, pre, 513 + int'(hp), 1 + int'(hp));
        end
        tests++;
        if (nrd != 256 || nwr != 256) begin
            fails++;
            $display("FAIL counts: reads=%0d writes=%0d, required 256 256", nrd, nwr);
        end
        if (mem_lb) begin
            tests++;
            if (last_wd !== 8'hFF) begin
                fails++;
                $display("FAIL last_wdata: %h, required ff", last_wd);
            end
        end
        if (!b2b) check_quiet("post_transfer");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h33;
        repeat (2) @(negedge clk);
        check_quiet("reset_with_trigger");
        rst = 1'b0;
        clear_cpu();
        @(negedge clk);
        check_quiet("after_reset");
    endtask

    task automatic test_parity0();
        mem_lb = 1'b0;
        start(8'h02, 0);
        monitor(8'h02, -10, 1'b0, 8'h00);
    endtask

    task automatic test_parity1();
        mem_lb = 1'b0;
        @(negedge clk);
        start(8'h02, 1);
        monitor(8'h02, -10, 1'b0, 8'h00);
    endtask

    task automatic test_lowbyte();
        mem_lb = 1'b1;
        start(8'h07, -1);
        monitor(8'h07, -10, 1'b0, 8'h00);
        mem_lb = 1'b0;
    endtask

    task automatic test_retrigger();
        start(8'h02, -1);
        monitor(8'h02, 100, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        start(8'h0A, -1);
        monitor(8'h0A, -10, 1'b1, 8'h0B);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL b2b_edge_trigger: stall=%b, required 0", stall);
        end
        @(negedge clk);
        clear_cpu();
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL b2b_idle_trigger: stall=%b, required 1", stall);
        end
        monitor(8'h0B, -10, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid();
        int n = 0, bad = 0;
        start(8'h03, -1);
        while (!(dma_rd === 1'b1 && dma_addr === 16'h0340) && n < 600) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n >= 600) begin
            fails++;
            $display("FAIL reset_mid_find: read of 0340 not seen, required within 600 cycles");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("reset_mid_next");
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stall !== 1'b0 || dma_rd !== 1'b0 || dma_we !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_no_resume: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_no_trigger();
        int bad = 0;
        cpu_we = 1'b1; cpu_addr = 16'h4015; cpu_wdata = 8'h02;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 16'h4014;
        repeat (3) @(negedge clk);
        clear_cpu();
        for (int i = 0; i < 10; i++) begin
            if (stall !== 1'b0 || dma_rd !== 1'b0 || dma_we !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_trigger: %0d active cycles, required 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_cpu();
        @(negedge clk);
        test_reset();
        test_parity0();
        test_parity1();
        test_lowbyte();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_no_trigger();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
